mem_pattern_test: RTL and testbench

Parametrised external-memory test engine. It sits on the SDRAM controller's burst user interface, in place of the address-as-data tester. It writes a configurable region burst by burst with one of four selectable data patterns, then reads the region back and compares it. Over repeated passes it reports a sticky error, a saturating error count, the first failing address, a pass count and a heartbeat for LED display.

---
 rtl/mem_pattern_test_if.sv | 34 +++
 rtl/mem_pattern_test.sv | 214 +++++++++++++++++++++
 tb/tb_mem_pattern_test.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pattern_test_if.sv
// Burst user interface between the memory test engine (master) and the
// SDRAM controller (slave).
interface mem_pattern_test_if #(
  parameter int MEM_DATA_BITS = 16,
  parameter int ADDR_BITS     = 24,
  parameter int BUSRT_BITS    = 10
);
  logic                     rd_burst_req;
  logic                     wr_burst_req;
  logic [BUSRT_BITS-1:0]    rd_burst_len;
  logic [BUSRT_BITS-1:0]    wr_burst_len;
  logic [ADDR_BITS-1:0]     rd_burst_addr;
  logic [ADDR_BITS-1:0]     wr_burst_addr;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_finish;
  logic                     rd_burst_finish;
  logic                     rd_burst_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;

  modport master (
    output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish, rd_burst_finish,
           rd_burst_data_valid, rd_burst_data
  );

  modport slave (
    input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish, rd_burst_finish,
           rd_burst_data_valid, rd_burst_data
  );
endinterface

// File: rtl/mem_pattern_test.sv
// External-memory pattern tester: writes a region burst by burst with a
// selectable pattern, reads it back, compares, and keeps pass/error status.
module mem_pattern_test #(
  parameter int MEM_DATA_BITS = 16,
  parameter int ADDR_BITS     = 24,
  parameter int BUSRT_BITS    = 10,
  parameter int BURST_SIZE    = 128,
  parameter int ADDR_BASE     = 0,
  parameter int ADDR_WORDS    = 4096,
  parameter logic [MEM_DATA_BITS-1:0] LFSR_TAPS = MEM_DATA_BITS'(16'hB400),
  parameter logic [MEM_DATA_BITS-1:0] LFSR_SEED = MEM_DATA_BITS'(16'hACE1)
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [1:0]           mode,
  mem_pattern_test_if.master   bus,
  output logic                 busy,
  output logic                 error,
  output logic [15:0]          err_count,
  output logic [ADDR_BITS-1:0] first_err_addr,
  output logic [15:0]          pass_count,
  output logic                 heartbeat
);

  localparam logic [ADDR_BITS-1:0]     BASE_A = ADDR_BITS'(ADDR_BASE);
  localparam logic [ADDR_BITS-1:0]     LAST_A = ADDR_BITS'(ADDR_BASE + ADDR_WORDS - BURST_SIZE);
  localparam logic [ADDR_BITS-1:0]     STEP_A = ADDR_BITS'(BURST_SIZE);
  localparam logic [ADDR_BITS-1:0]     MOD_A  = ADDR_BITS'(MEM_DATA_BITS);
  localparam logic [MEM_DATA_BITS-1:0] ONE_D  = MEM_DATA_BITS'(1);
  localparam logic [BUSRT_BITS-1:0]    ONE_B  = BUSRT_BITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     req_q;
  logic [ADDR_BITS-1:0]     burst_addr_q;
  logic [1:0]               cur_mode_q;
  logic [MEM_DATA_BITS-1:0] lfsr_q;
  logic [BUSRT_BITS-1:0]    wr_beat_q, rd_beat_q;
  logic [MEM_DATA_BITS-1:0] wr_data_q;
  logic                     error_q;
  logic [15:0]              err_count_q;
  logic [ADDR_BITS-1:0]     first_err_addr_q;
  logic [15:0]              pass_count_q;
  logic                     heartbeat_q;

  logic                     wr_req, rd_req, busy_c;
  logic                     finish, last_burst, enter_write, enter_read;
  logic                     wr_beat_go, rd_beat_go, mismatch;
  logic [ADDR_BITS-1:0]     wr_word_addr, rd_word_addr;
  logic [MEM_DATA_BITS-1:0] expected;

  // Data word for address a under pattern m; mode 3 simply returns the LFSR.
  function automatic logic [MEM_DATA_BITS-1:0] pattern(input logic [1:0] m,
                                                       input logic [ADDR_BITS-1:0] a,
                                                       input logic [MEM_DATA_BITS-1:0] lfsr);
    logic [MEM_DATA_BITS-1:0] a_lo;
    logic [ADDR_BITS-1:0]     bit_idx;
    a_lo    = MEM_DATA_BITS'(a);
    bit_idx = a % MOD_A;
    case (m)
      2'd0:    return a_lo;
      2'd1:    return ~a_lo;
      2'd2:    return ONE_D << bit_idx;
      default: return lfsr;
    endcase
  endfunction

  // One Galois LFSR step, shifting right and folding the taps on a 1 out.
  function automatic logic [MEM_DATA_BITS-1:0] lfsr_step(input logic [MEM_DATA_BITS-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  assign last_burst   = (burst_addr_q == LAST_A);
  assign finish       = (wr_req & bus.wr_burst_finish) | (rd_req & bus.rd_burst_finish);
  assign enter_write  = (state_d == S_WRITE) && (state_q != S_WRITE);
  assign enter_read   = (state_d == S_READ) && (state_q != S_READ);
  assign wr_beat_go   = wr_req & bus.wr_burst_data_req;
  assign rd_beat_go   = rd_req & bus.rd_burst_data_valid;
  assign wr_word_addr = burst_addr_q + ADDR_BITS'(wr_beat_q);
  assign rd_word_addr = burst_addr_q + ADDR_BITS'(rd_beat_q);
  assign expected     = pattern(cur_mode_q, rd_word_addr, lfsr_q);
  assign mismatch     = rd_beat_go && (bus.rd_burst_data != expected);

  // State register.
  always_ff @(posedge mem_clk or posedge rst) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: enable is honoured only between bursts, never mid-request.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_WRITE;
      S_WRITE: begin
        if (req_q) begin
          if (bus.wr_burst_finish) begin
            if (!enable)        state_d = S_IDLE;
            else if (last_burst) state_d = S_READ;
          end
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (req_q) begin
          if (bus.rd_burst_finish) begin
            if (last_burst)   state_d = S_DONE;
            else if (!enable) state_d = S_IDLE;
          end
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = enable ? S_WRITE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state: requests are qualified by the phase.
  always_comb begin
    wr_req = 1'b0;
    rd_req = 1'b0;
    case (state_q)
      S_WRITE: wr_req = req_q;
      S_READ:  rd_req = req_q;
      default: ;
    endcase
    busy_c = (state_q != S_IDLE);
  end

  // Burst sequencing, beat counters, pattern generation and LFSR.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      req_q        <= 1'b0;
      burst_addr_q <= '0;
      cur_mode_q   <= 2'd0;
      lfsr_q       <= LFSR_SEED;
      wr_beat_q    <= '0;
      rd_beat_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      if (finish)
        req_q <= 1'b0;
      else if ((state_q == S_WRITE || state_q == S_READ) && state_d == state_q && !req_q)
        req_q <= 1'b1;

      if (enter_write) begin
        burst_addr_q <= BASE_A;
        cur_mode_q   <= mode;
      end else if (finish) begin
        burst_addr_q <= last_burst ? BASE_A : burst_addr_q + STEP_A;
      end

      if (finish || enter_write || enter_read) begin
        wr_beat_q <= '0;
        rd_beat_q <= '0;
      end else begin
        if (wr_beat_go) wr_beat_q <= wr_beat_q + ONE_B;
        if (rd_beat_go) rd_beat_q <= rd_beat_q + ONE_B;
      end

      if (wr_beat_go) wr_data_q <= pattern(cur_mode_q, wr_word_addr, lfsr_q);

      if (enter_write || enter_read)  lfsr_q <= LFSR_SEED;
      else if (wr_beat_go || rd_beat_go) lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  // Error status; clear wins over a mismatch in the same cycle.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst || clear) begin
      error_q          <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else if (mismatch) begin
      error_q <= 1'b1;
      if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      if (!error_q) first_err_addr_q <= rd_word_addr;
    end
  end

  // Pass counter and heartbeat advance once per completed pass.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      pass_count_q <= '0;
      heartbeat_q  <= 1'b0;
    end else if (state_q == S_DONE) begin
      pass_count_q <= pass_count_q + 16'd1;
      heartbeat_q  <= ~heartbeat_q;
    end
  end

  assign bus.wr_burst_req  = wr_req;
  assign bus.rd_burst_req  = rd_req;
  assign bus.wr_burst_len  = BUSRT_BITS'(BURST_SIZE);
  assign bus.rd_burst_len  = BUSRT_BITS'(BURST_SIZE);
  assign bus.wr_burst_addr = burst_addr_q;
  assign bus.rd_burst_addr = burst_addr_q;
  assign bus.wr_burst_data = wr_data_q;

  assign busy           = busy_c;
  assign error          = error_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign pass_count     = pass_count_q;
  assign heartbeat      = heartbeat_q;

endmodule

// File: tb/tb_mem_pattern_test.sv
// Directed bench for mem_pattern_test with a behavioural burst memory.
module tb_mem_pattern_test;

  localparam int BS    = 4;
  localparam int WORDS = 16;
  localparam int BASE  = 'h100;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [1:0]  mode;
  logic        busy;
  logic        error;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;
  logic [15:0] pass_count;
  logic        heartbeat;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:WORDS-1];
  logic [15:0] inj [0:WORDS-1];
  logic [23:0] wr_log [$];
  logic [23:0] rd_log [$];

  mem_pattern_test_if #(.MEM_DATA_BITS(16), .ADDR_BITS(24), .BUSRT_BITS(10)) bus ();

  mem_pattern_test #(
    .MEM_DATA_BITS(16), .ADDR_BITS(24), .BUSRT_BITS(10),
    .BURST_SIZE(BS), .ADDR_BASE(BASE), .ADDR_WORDS(WORDS)
  ) dut (
    .mem_clk        (clk),
    .rst            (rst),
    .enable         (enable),
    .clear          (clear),
    .mode           (mode),
    .bus            (bus.master),
    .busy           (busy),
    .error          (error),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .pass_count     (pass_count),
    .heartbeat      (heartbeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural memory behind the controller ----------------
  task automatic serve_write(input logic [23:0] base);
    bit aborted = 0;
    int idx;
    wr_log.push_back(base);
    repeat (2) begin
      @(negedge clk);
      if (rst) aborted = 1;
    end
    if (!aborted) begin
      bus.wr_burst_data_req = 1'b1;
      for (int i = 0; i < BS && !aborted; i++) begin
        @(negedge clk);
        if (rst) aborted = 1;
        else begin
          idx = int'(base) + i - BASE;
          if (idx >= 0 && idx < WORDS) mem[idx] = bus.wr_burst_data;
        end
        if (i == BS - 1 || aborted) bus.wr_burst_data_req = 1'b0;
      end
    end
    bus.wr_burst_data_req = 1'b0;
    if (!aborted) begin
      bus.wr_burst_finish = 1'b1;
      @(negedge clk);
      bus.wr_burst_finish = 1'b0;
    end
  endtask

  task automatic serve_read(input logic [23:0] base);
    bit aborted = 0;
    int idx;
    rd_log.push_back(base);
    repeat (2) begin
      @(negedge clk);
      if (rst) aborted = 1;
    end
    for (int i = 0; i < BS && !aborted; i++) begin
      idx = int'(base) + i - BASE;
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data = (idx >= 0 && idx < WORDS) ? (mem[idx] ^ inj[idx]) : 16'h0000;
      @(negedge clk);
      if (rst) aborted = 1;
    end
    bus.rd_burst_data_valid = 1'b0;
    if (!aborted) begin
      bus.rd_burst_finish = 1'b1;
      @(negedge clk);
      bus.rd_burst_finish = 1'b0;
    end
  endtask

  initial begin : model
    bus.wr_burst_data_req   = 1'b0;
    bus.wr_burst_finish     = 1'b0;
    bus.rd_burst_finish     = 1'b0;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data       = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst && bus.wr_burst_req)      serve_write(bus.wr_burst_addr);
      else if (!rst && bus.rd_burst_req) serve_read(bus.rd_burst_addr);
    end
  end

  // ---------------- helpers ----------------
  task automatic run_pass(input logic [15:0] target);
    wr_log.delete();
    rd_log.delete();
    enable = 1'b1;
    for (int n = 0; n < 2000 && pass_count != target; n++) @(negedge clk);
    check("pass_count", pass_count, target);
    enable = 1'b0;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    check("back_idle", busy, 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic clear_inj();
    for (int i = 0; i < WORDS; i++) inj[i] = 16'h0000;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [23:0] a;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; mode = 2'd0;
    for (int i = 0; i < WORDS; i++) mem[i] = 16'h0000;
    clear_inj();
    repeat (3) @(negedge clk);

    check("rst_wr_req", bus.wr_burst_req, 0);
    check("rst_rd_req", bus.rd_burst_req, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err", first_err_addr, 0);
    check("rst_pass_count", pass_count, 0);
    check("rst_heartbeat", heartbeat, 0);
    check("rst_wr_data", bus.wr_burst_data, 0);
    check("rst_wr_addr", bus.wr_burst_addr, 0);

    rst = 1'b0;
    @(negedge clk);

    // mode 0: address as data
    mode = 2'd0;
    run_pass(16'd1);
    for (int i = 0; i < 4; i++) begin
      a = (i < wr_log.size()) ? wr_log[i] : 24'hFFFFFF;
      check("m0_wr_addr", a, BASE + 4 * i);
      a = (i < rd_log.size()) ? rd_log[i] : 24'hFFFFFF;
      check("m0_rd_addr", a, BASE + 4 * i);
    end
    check("m0_word_105", mem[5], 16'h0105);
    check("m0_heartbeat", heartbeat, 1);
    check("m0_error", error, 0);

    // mode 1: inverted address
    mode = 2'd1;
    run_pass(16'd2);
    check("m1_word_103", mem[3], 16'hFEFC);
    check("m1_error", error, 0);
    check("m1_heartbeat", heartbeat, 0);

    // mode 2: walking one
    mode = 2'd2;
    run_pass(16'd3);
    check("m2_word_103", mem[3], 16'h0008);
    check("m2_word_10F", mem[15], 16'h8000);
    check("m2_error", error, 0);

    // mode 3: LFSR 0xACE1 -> 0xE270
    mode = 2'd3;
    run_pass(16'd4);
    check("m3_word_100", mem[0], 16'hACE1);
    check("m3_word_101", mem[1], 16'hE270);
    check("m3_error", error, 0);

    // injected read errors at 0x106 and 0x10B
    mode = 2'd0;
    inj[6]  = 16'h0001;
    inj[11] = 16'h8000;
    run_pass(16'd5);
    check("inj_error", error, 1);
    check("inj_err_count", err_count, 2);
    check("inj_first_err", first_err_addr, 24'h000106);
    run_pass(16'd6);
    check("inj2_err_count", err_count, 4);
    check("inj2_first_err", first_err_addr, 24'h000106);

    pulse_clear();
    check("clr_error", error, 0);
    check("clr_err_count", err_count, 0);
    check("clr_first_err", first_err_addr, 0);
    check("clr_pass_count", pass_count, 6);

    // saturation from 0xFFFE with three mismatches
    force dut.err_count_q = 16'hFFFE;
    #1;
    release dut.err_count_q;
    clear_inj();
    inj[1] = 16'h0010;
    inj[2] = 16'h0010;
    inj[3] = 16'h0010;
    run_pass(16'd7);
    check("sat_err_count", err_count, 16'hFFFF);
    check("sat_first_err", first_err_addr, 24'h000101);
    check("sat_error", error, 1);
    clear_inj();
    pulse_clear();

    // drop enable while the 0x108 write burst is requested
    wr_log.delete();
    rd_log.delete();
    enable = 1'b1;
    for (int n = 0; n < 1000 && !(bus.wr_burst_req && bus.wr_burst_addr == 24'h000108); n++)
      @(negedge clk);
    check("drop_req_addr", bus.wr_burst_addr, 24'h000108);
    enable = 1'b0;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    check("drop_busy", busy, 0);
    check("drop_wr_bursts", wr_log.size(), 3);
    a = (wr_log.size() > 0) ? wr_log[wr_log.size() - 1] : 24'hFFFFFF;
    check("drop_last_addr", a, 24'h000108);
    check("drop_rd_bursts", rd_log.size(), 0);
    check("drop_wr_req", bus.wr_burst_req, 0);

    wr_log.delete();
    enable = 1'b1;
    for (int n = 0; n < 100 && wr_log.size() == 0; n++) @(negedge clk);
    a = (wr_log.size() > 0) ? wr_log[0] : 24'hFFFFFF;
    check("restart_addr", a, 24'h000100);
    enable = 1'b0;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    check("restart_idle", busy, 0);

    // async reset in the middle of a read burst
    inj[0] = 16'h00FF;
    enable = 1'b1;
    for (int n = 0; n < 2000 && !error; n++) @(negedge clk);
    check("pre_rst_error", error, 1);
    check("pre_rst_rd_req", bus.rd_burst_req, 1);
    rst = 1'b1;
    #1;
    check("arst_rd_req", bus.rd_burst_req, 0);
    check("arst_wr_req", bus.wr_burst_req, 0);
    check("arst_error", error, 0);
    check("arst_err_count", err_count, 0);
    check("arst_first_err", first_err_addr, 0);
    check("arst_pass_count", pass_count, 0);
    check("arst_heartbeat", heartbeat, 0);
    check("arst_busy", busy, 0);
    inj[0] = 16'h0000;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    run_pass(16'd1);
    check("post_rst_error", error, 0);
    check("post_rst_err_count", err_count, 0);
    check("post_rst_rd_bursts", rd_log.size(), 4);
    check("post_rst_heartbeat", heartbeat, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
